mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port data/instruction memory (mem_rw bank) between three requesters:
  - the external program loader (mem_write/mem_in path);
  - the execute-stage load/store unit;
  - the fetch stage.
- Issues one memory access per cycle and routes the 1-cycle-latency read data back to the correct requester.
- Generates stall signals for the pipeline and prevents fetch starvation.
- Sits between top's pipeline stages and the memory instance.

Parameters:
- WORD, 32, data width (from params.v).
- ADDR, 8, memory word-address width (256-entry bank).
- STARVE_MAX, 4, consecutive fetch denials before fetch is promoted above execute.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; state clears on a rising clk edge while reset==0.
- ld_req  in  1  loader write request.
- ld_addr  in  ADDR  loader address.
- ld_wdata  in  WORD  loader write data.
- ex_req  in  1  execute access request.
- ex_we  in  1  execute write (1) / read (0).
- ex_addr  in  ADDR  execute address.
- ex_wdata  in  WORD  execute write data.
- if_req  in  1  fetch read request.
- if_addr  in  ADDR  fetch address.
- ld_gnt  out  1  loader granted this cycle.
- ex_gnt  out  1  execute granted this cycle.
- if_gnt  out  1  fetch granted this cycle.
- stall_ex  out  1  ex_req && !ex_gnt.
- stall_if  out  1  if_req && !if_gnt.
- ex_rvalid  out  1  rdata belongs to the execute read granted last cycle.
- if_rvalid  out  1  rdata belongs to the fetch granted last cycle.
- rdata  out  WORD  read data, forwarded from mem_rdata.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR  memory address.
- mem_wdata  out  WORD  memory write data.
- mem_rdata  in  WORD  memory read data, valid one cycle after a read with mem_en=1.
- conflict_cnt  out  32  contention counter (see Optional Feature).

Behaviour:
- Grant logic: combinational from current requests plus the registered promote flag. At most one gnt is high per cycle.
  - Normal priority: loader > execute > fetch.
  - promote==1: loader > fetch > execute.
  - Requests are level-held; a denied requester keeps its req and operands stable until granted. The arbiter does not check this.
- Memory port mux:
  - mem_en = any gnt.
  - mem_we = ld_gnt | (ex_gnt & ex_we).
  - mem_addr and mem_wdata come from the granted requester.
  - Fetch always reads; mem_wdata = 0 when fetch is granted.
  - When idle, mem_addr = 0 and mem_wdata = 0.
- Response tracking: registered tag {ex_rd, if_rd} set on the edge after a read grant.
  - ex_rvalid = tag.ex_rd; if_rvalid = tag.if_rd; rdata = mem_rdata, passed through combinationally.
  - Writes produce no rvalid.
  - Back-to-back reads are allowed every cycle; tag updates each cycle.
- Starvation counter starve_cnt: width clog2(STARVE_MAX+1).
  - Increments when if_req && !if_gnt && !ld_gnt.
  - Clears on if_gnt or !if_req.
  - Saturates at STARVE_MAX.
  - promote = (starve_cnt == STARVE_MAX), registered.
  - promote clears the cycle after fetch is granted.
  - Loader activity holds the counter rather than incrementing it. Loading is initialisation, not contention.
- Simultaneous events:
  - Loader plus anything: loader wins, and the others stall.
  - ex and if on the same cycle: execute wins unless promote is set.
- Reset (reset==0 at an edge):
  - starve_cnt = 0, promote = 0, tag = 0, conflict_cnt = 0.
  - Therefore ex_rvalid = if_rvalid = 0 the cycle after reset.
  - An in-flight read's response is dropped.
  - Combinational outputs follow the inputs, but all gnt are forced to 0 while reset==0, so mem_en = 0 and both stalls = req.
- Latency: grant in cycle N, read data valid with rvalid in N+1.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined: conflict_cnt increments (saturating at 32'hFFFFFFFF) every cycle in which two or more of ld_req, ex_req, if_req are high; it clears on reset.
- Undefined: no counter logic is built, and conflict_cnt is tied to 32'h0.

Decomposition:
- Shared package/include (params.v): WORD, ADDR.
- New constants there:
  - requester index localparams REQ_LD=0, REQ_EX=1, REQ_IF=2.
  - default STARVE_MAX.
- One natural sub-module: mem_arb_prio. It is a pure combinational fixed-priority select taking a 3-bit req vector and a promote bit and returning a one-hot 3-bit gnt. The top module holds the counters, tag register and port mux.

Test Plan:
- Reset: hold reset=0 for 2 cycles with all reqs=1 -> all gnt=0, mem_en=0, stall_ex=stall_if=1, and the cycle after release both rvalid=0 and conflict_cnt=0.
- Loader burst: ld_req=1 writing addr 0..3 with data 0xA0..0xA3 while if_req=1 -> ld_gnt each cycle, mem_we=1, stall_if=1 for 4 cycles, and starve_cnt does not advance (if_gnt on the first cycle after the burst).
- Execute read: ex_req=1, ex_we=0, addr 0x10 (mem holds 0xDEADBEEF) -> ex_gnt in N, ex_rvalid=1 and rdata=0xDEADBEEF in N+1, if_rvalid=0.
- Contention/starvation with STARVE_MAX=4: ex_req and if_req held high -> ex_gnt for 4 cycles, then if_gnt on cycle 5 (promote), then ex_gnt resumes on cycle 6.
- Back-to-back mixed: alternating if read addr 1 / ex write addr 2 data 0x55 -> if_rvalid only after the fetch cycles, no rvalid after the write, and mem[2]=0x55.
- MEM_ARB_PERF_EN defined, 10 cycles with ex_req and if_req both high -> conflict_cnt=10; rebuilt without the macro -> conflict_cnt=0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared widths, requester indices and helpers for the memory port arbiter
package mem_port_arbiter_pkg;

    localparam int WORD = 32;
    localparam int ADDR = 8;
    localparam int DEF_STARVE_MAX = 4;

    localparam int NREQ   = 3;
    localparam int REQ_LD = 0;
    localparam int REQ_EX = 1;
    localparam int REQ_IF = 2;

    typedef logic [NREQ-1:0] req_vec_t;

    typedef struct packed {
        logic ex_rd;
        logic if_rd;
    } rsp_tag_t;

    // True when at least two requesters compete in the same cycle.
    function automatic logic multi_req(input req_vec_t r);
        return (r[0] & r[1]) | (r[0] & r[2]) | (r[1] & r[2]);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side bundle of the memory port arbiter
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic            ld_req;
    logic [ADDR-1:0] ld_addr;
    logic [WORD-1:0] ld_wdata;
    logic            ex_req;
    logic            ex_we;
    logic [ADDR-1:0] ex_addr;
    logic [WORD-1:0] ex_wdata;
    logic            if_req;
    logic [ADDR-1:0] if_addr;
    logic            ld_gnt;
    logic            ex_gnt;
    logic            if_gnt;
    logic            stall_ex;
    logic            stall_if;
    logic            ex_rvalid;
    logic            if_rvalid;
    logic [WORD-1:0] rdata;
    logic            mem_en;
    logic            mem_we;
    logic [ADDR-1:0] mem_addr;
    logic [WORD-1:0] mem_wdata;
    logic [WORD-1:0] mem_rdata;
    logic [31:0]     conflict_cnt;

    modport slave (
        input  ld_req, ld_addr, ld_wdata,
        input  ex_req, ex_we, ex_addr, ex_wdata,
        input  if_req, if_addr,
        input  mem_rdata,
        output ld_gnt, ex_gnt, if_gnt, stall_ex, stall_if,
        output ex_rvalid, if_rvalid, rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output conflict_cnt
    );

    modport master (
        output ld_req, ld_addr, ld_wdata,
        output ex_req, ex_we, ex_addr, ex_wdata,
        output if_req, if_addr,
        output mem_rdata,
        input  ld_gnt, ex_gnt, if_gnt, stall_ex, stall_if,
        input  ex_rvalid, if_rvalid, rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  conflict_cnt
    );

endinterface

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - combinational fixed-priority select; promote swaps fetch above execute
module mem_arb_prio
    import mem_port_arbiter_pkg::*;
(
    input  req_vec_t req,
    input  logic     promote,
    output req_vec_t gnt
);

    always_comb begin
        gnt = '0;
        if (req[REQ_LD]) begin
            gnt[REQ_LD] = 1'b1;
        end else if (promote) begin
            if (req[REQ_IF])      gnt[REQ_IF] = 1'b1;
            else if (req[REQ_EX]) gnt[REQ_EX] = 1'b1;
        end else begin
            if (req[REQ_EX])      gnt[REQ_EX] = 1'b1;
            else if (req[REQ_IF]) gnt[REQ_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for loader/execute/fetch with anti-starvation
// Optional contention counter built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] MAX_C = CW'(STARVE_MAX);

    req_vec_t      req;
    req_vec_t      raw_gnt;
    req_vec_t      gnt;
    logic          promote_q;
    logic [CW-1:0] starve_q;
    logic [CW-1:0] starve_next;
    rsp_tag_t      tag_q;

    always_comb begin
        req         = '0;
        req[REQ_LD] = bus.ld_req;
        req[REQ_EX] = bus.ex_req;
        req[REQ_IF] = bus.if_req;
    end

    mem_arb_prio u_prio (
        .req     (req),
        .promote (promote_q),
        .gnt     (raw_gnt)
    );

    assign gnt = reset ? raw_gnt : '0;

    assign bus.ld_gnt   = gnt[REQ_LD];
    assign bus.ex_gnt   = gnt[REQ_EX];
    assign bus.if_gnt   = gnt[REQ_IF];
    assign bus.stall_ex = bus.ex_req & ~gnt[REQ_EX];
    assign bus.stall_if = bus.if_req & ~gnt[REQ_IF];

    always_comb begin
        bus.mem_en    = |gnt;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (gnt[REQ_LD]) begin
            bus.mem_we    = 1'b1;
            bus.mem_addr  = bus.ld_addr;
            bus.mem_wdata = bus.ld_wdata;
        end else if (gnt[REQ_EX]) begin
            bus.mem_we    = bus.ex_we;
            bus.mem_addr  = bus.ex_addr;
            bus.mem_wdata = bus.ex_wdata;
        end else if (gnt[REQ_IF]) begin
            bus.mem_addr  = bus.if_addr;
        end
    end

    // Loader traffic is initialisation, so it freezes the starvation count instead of advancing it.
    always_comb begin
        starve_next = starve_q;
        if (!bus.if_req || gnt[REQ_IF]) begin
            starve_next = '0;
        end else if (!gnt[REQ_LD] && starve_q != MAX_C) begin
            starve_next = starve_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_q  <= '0;
            promote_q <= 1'b0;
            tag_q     <= '0;
        end else begin
            starve_q     <= starve_next;
            promote_q    <= (starve_next == MAX_C);
            tag_q.ex_rd  <= gnt[REQ_EX] & ~bus.ex_we;
            tag_q.if_rd  <= gnt[REQ_IF];
        end
    end

    assign bus.ex_rvalid = tag_q.ex_rd;
    assign bus.if_rvalid = tag_q.if_rd;
    assign bus.rdata     = bus.mem_rdata;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] conflict_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            conflict_q <= '0;
        end else if (multi_req(req) && conflict_q != 32'hFFFF_FFFF) begin
            conflict_q <= conflict_q + 32'd1;
        end
    end

    assign bus.conflict_cnt = conflict_q;
`else
    assign bus.conflict_cnt = 32'h0;
`endif

endmodule
